buffer_ctrl: RTL and testbench

//   Pointer/flow controller that drives the write and read sides of a TCU register-array buffer
//   (2**ADDR_BW entries, registered write, combinational read gated by rd_en).

---
 rtl/buffer_ctrl.sv | 130 +++++++++++++
 tb/tb_buffer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/buffer_ctrl.sv
// buffer_ctrl
//   Pointer/flow controller for a register-array buffer of DEPTH = 2**ADDR_BW
//   entries. The buffer writes on wr_en at wr_ptr (registered write). It reads
//   combinationally at rd_ptr, gated by rd_en. This controller turns the
//   producer and consumer valid/ready handshakes into those controls. The
//   result is FIFO order, plus occupancy and sticky error flags.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   flush        synchronous clear of pointers, count and error flags
//   in_valid     producer offers an entry
//   in_ready     entry accepted this cycle (= !full)
//   out_valid    head entry present on the buffer's dout (= !empty)
//   out_ready    consumer takes the head entry
//   wr_en        buffer write enable (= in_valid & !full)
//   wr_ptr       buffer write address (tail)
//   rd_en        buffer read enable (= !empty)
//   rd_ptr       buffer read address (head)
//   count        number of stored entries, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AFULL_TH
//   ovf_err      sticky: in_valid seen while full
//   udf_err      sticky: out_ready seen while empty
module buffer_ctrl #(
  parameter int ADDR_BW  = 1,
  parameter int AFULL_TH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               wr_en,
  output logic [ADDR_BW-1:0] wr_ptr,
  output logic               rd_en,
  output logic [ADDR_BW-1:0] rd_ptr,
  output logic [ADDR_BW:0]   count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               ovf_err,
  output logic               udf_err
);

  localparam int               DEPTH    = 2 ** ADDR_BW;
  localparam logic [ADDR_BW:0] DEPTH_C  = (ADDR_BW + 1)'(DEPTH);
  localparam logic [ADDR_BW:0] AFULL_C  = (ADDR_BW + 1)'(AFULL_TH);
  localparam logic [ADDR_BW:0] ONE_CNT  = (ADDR_BW + 1)'(1);
  localparam logic [ADDR_BW-1:0] ONE_PTR = ADDR_BW'(1);

  logic [ADDR_BW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_BW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_BW:0]   count_reg,  count_next;
  logic               ovf_reg,    ovf_next;
  logic               udf_reg,    udf_next;

  logic push;
  logic pop;

  // Flags are decoded from count alone, so pointer equality never matters
  // when the pointers wrap.
  assign full        = (count_reg == DEPTH_C);
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= AFULL_C);

  // No pass-through: a full buffer refuses a push even if it pops in the
  // same cycle. That keeps the write path independent of out_ready.
  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign rd_en     = ~empty;
  // wr_en is not masked by flush. A write during the flush cycle lands in a
  // slot that becomes unreachable once count is cleared.
  assign wr_en     = push;

  assign wr_ptr  = wr_ptr_reg;
  assign rd_ptr  = rd_ptr_reg;
  assign count   = count_reg;
  assign ovf_err = ovf_reg;
  assign udf_err = udf_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg | (in_valid & full);
    udf_next    = udf_reg | (out_ready & empty);

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      ovf_next    = 1'b0;
      udf_next    = 1'b0;
    end else begin
      // Pointers wrap naturally modulo DEPTH through the ADDR_BW width.
      if (push) wr_ptr_next = wr_ptr_reg + ONE_PTR;
      if (pop)  rd_ptr_next = rd_ptr_reg + ONE_PTR;
      // push needs !full and pop needs !empty, so count stays in 0..DEPTH.
      case ({push, pop})
        2'b10:   count_next = count_reg + ONE_CNT;
        2'b01:   count_next = count_reg - ONE_CNT;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed testbench for buffer_ctrl (ADDR_BW=2, AFULL_TH=3) with a small
// register-array buffer model driven by the controller's wr/rd signals.
module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] din = 8'h00;
  logic       in_ready, out_valid, wr_en, rd_en;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, empty, almost_full, ovf_err, udf_err;

  logic [7:0] mem [4];
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  buffer_ctrl #(.ADDR_BW(2), .AFULL_TH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .wr_en(wr_en), .wr_ptr(wr_ptr), .rd_en(rd_en), .rd_ptr(rd_ptr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  // Buffer model: registered write, combinational gated read.
  always @(posedge clk) if (wr_en) mem[wr_ptr] <= din;
  assign dout = rd_en ? mem[rd_ptr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // T1 reset
    #12;
    check("t1_rst_count", count, 0);
    check("t1_rst_empty", empty, 1);
    rst = 1'b1;
    step();
    check("t1_count", count, 0);
    check("t1_empty", empty, 1);
    check("t1_full", full, 0);
    check("t1_afull", almost_full, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_rd_en", rd_en, 0);
    check("t1_wr_en", wr_en, 0);
    check("t1_wr_ptr", wr_ptr, 0);
    check("t1_rd_ptr", rd_ptr, 0);
    check("t1_errs", {ovf_err, udf_err}, 0);

    // T2 fill then drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      din = 8'hA1 + 8'(i);
      #1;
      check("t2_wr_en", wr_en, 1);
      if (i == 0) check("t2_no_bypass", out_valid, 0);
      step();
      check("t2_count", count, i + 1);
      check("t2_afull", almost_full, (i >= 2) ? 1 : 0);
      if (i == 0) begin
        check("t2_lat_valid", out_valid, 1);
        check("t2_lat_dout", dout, 8'hA1);
      end
    end
    in_valid = 1'b0;
    #1;
    check("t2_full", full, 1);
    check("t2_in_ready", in_ready, 0);
    check("t2_count4", count, 4);
    check("t2_wr_ptr_wrap", wr_ptr, 0);
    for (int i = 0; i < 4; i++) begin
      check("t2_out_valid", out_valid, 1);
      check("t2_dout", dout, 8'hA1 + 8'(i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    #1;
    check("t2_empty", empty, 1);
    check("t2_count0", count, 0);
    check("t2_rd_ptr", rd_ptr, 0);
    check("t2_no_udf", udf_err, 0);

    // T3 concurrent push/pop at count=2
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      din = 8'h10 + 8'(i);
      step();
    end
    check("t3_count_start", count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din = 8'h12 + 8'(k);
      #1;
      check("t3_head", dout, 8'h10 + 8'(k));
      step();
      check("t3_count", count, 2);
    end
    in_valid = 1'b0;
    check("t3_wr_ptr", wr_ptr, 0);
    check("t3_rd_ptr", rd_ptr, 2);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t3_drain", dout, 8'h1A + 8'(k));
      step();
    end
    out_ready = 1'b0;
    check("t3_empty", empty, 1);
    check("t3_ptrs", {wr_ptr, rd_ptr}, 0);

    // T4 full refusal with simultaneous pop
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'h20 + 8'(i);
      step();
    end
    check("t4_full", full, 1);
    din = 8'h99;
    out_ready = 1'b1;
    #1;
    check("t4_wr_en", wr_en, 0);
    check("t4_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t4_count", count, 3);
    check("t4_ovf", ovf_err, 1);
    check("t4_rd_ptr", rd_ptr, 1);
    check("t4_wr_ptr", wr_ptr, 0);
    check("t4_dout", dout, 8'h21);
    step();
    check("t4_ovf_sticky", ovf_err, 1);

    // T5 underflow, then flush with a push
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_drain", dout, 8'h21 + 8'(i));
      step();
    end
    check("t5_empty", empty, 1);
    step();
    out_ready = 1'b0;
    check("t5_udf", udf_err, 1);
    check("t5_udf_count", count, 0);
    check("t5_udf_rd_ptr", rd_ptr, 0);
    in_valid = 1'b1;
    din = 8'h30;
    step();
    check("t5_push_wr_ptr", wr_ptr, 1);
    flush = 1'b1;
    #1;
    check("t5_flush_wr_en", wr_en, 1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_fl_count", count, 0);
    check("t5_fl_errs", {ovf_err, udf_err}, 0);
    check("t5_fl_ptrs", {wr_ptr, rd_ptr}, 0);
    check("t5_fl_empty", empty, 1);

    // T6 async reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'h40 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("t6_count3", count, 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_wr_ptr", wr_ptr, 0);
    step();
    rst = 1'b1;
    step();
    check("t6_after", {count, wr_ptr, rd_ptr}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
